// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared FunSel codes, timeout counter width and FSM state encoding for the
// two-byte instruction fetch sequencer.
package ir_fetch_sequencer_pkg;

  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_WL_CLRH = 3'b100;
  localparam logic [2:0] FS_WL      = 3'b101;
  localparam logic [2:0] FS_WH      = 3'b110;
  localparam logic [2:0] FS_SEXT    = 3'b111;

  // TIMEOUT is bounded to 1..255, so an 8-bit count always covers TIMEOUT-1.
  localparam int TMO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BYTE0 = 3'd1,
    ST_BYTE1 = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

  // IR write mode for a byte: the first byte also clears the other half only
  // when it lands in the low byte, so a fetch never leaves stale high bits.
  function automatic logic [2:0] byte_funsel(input logic low_first,
                                             input logic second_byte);
    if (low_first) begin
      return second_byte ? FS_WH : FS_WL_CLRH;
    end
    return second_byte ? FS_WL : FS_WH;
  endfunction

endpackage

// File: rtl/ir_fetch_sequencer_timeout.sv
// Per-byte handshake watchdog: counts cycles a memory request waits for its
// ack and flags the terminal count TIMEOUT-1.
module fetch_timeout_counter
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [TMO_W-1:0] TC_VALUE = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_count;

  assign o_terminal = (r_count == TC_VALUE);

  // Holding at terminal count keeps the flag stable if the FSM ever lingers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Fetches one 16-bit instruction as two byte reads, steering IR byte writes
// and PC increments; aborts a byte that waits TIMEOUT cycles for its ack.
//   state | meaning
//   IDLE  | waiting for Start
//   BYTE0 | first byte requested; ack writes IR and bumps PC
//   BYTE1 | second byte requested; ack writes IR and bumps PC
//   DONE  | one-cycle Done pulse
//   ERR   | one-cycle Err pulse after a timeout
module ir_fetch_sequencer
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_pc_q,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_ir_e,
  output logic [2:0]  o_ir_funsel,
  output logic [15:0] o_ir_i,
  output logic        o_pc_e,
  output logic [2:0]  o_pc_funsel,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         w_in_fetch;
  logic         w_tmo_clear;
  logic         w_tmo_enable;
  logic         w_tmo_tc;

  assign w_in_fetch   = (r_state == ST_BYTE0) || (r_state == ST_BYTE1);
  assign w_tmo_clear  = !w_in_fetch || i_mem_ack;
  assign w_tmo_enable = w_in_fetch && !i_mem_ack;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_tmo_clear),
    .i_enable   (w_tmo_enable),
    .o_terminal (w_tmo_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An ack in the terminal-count cycle takes priority over the abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_BYTE0;
      end
      ST_BYTE0: begin
        if (i_mem_ack)     w_state_nxt = ST_BYTE1;
        else if (w_tmo_tc) w_state_nxt = ST_ERR;
      end
      ST_BYTE1: begin
        if (i_mem_ack)     w_state_nxt = ST_DONE;
        else if (w_tmo_tc) w_state_nxt = ST_ERR;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_ir_e      = 1'b0;
    o_pc_e      = 1'b0;
    o_ir_funsel = byte_funsel(LOW_FIRST, 1'b0);
    case (r_state)
      ST_BYTE0: begin
        o_mem_req   = 1'b1;
        o_busy      = 1'b1;
        o_ir_funsel = byte_funsel(LOW_FIRST, 1'b0);
        o_ir_e      = i_mem_ack;
        o_pc_e      = i_mem_ack;
      end
      ST_BYTE1: begin
        o_mem_req   = 1'b1;
        o_busy      = 1'b1;
        o_ir_funsel = byte_funsel(LOW_FIRST, 1'b1);
        o_ir_e      = i_mem_ack;
        o_pc_e      = i_mem_ack;
      end
      ST_DONE:  o_done = 1'b1;
      ST_ERR:   o_err  = 1'b1;
      default:  ;
    endcase
  end

  assign o_mem_addr  = i_pc_q;
  assign o_ir_i      = {8'h00, i_mem_data};
  assign o_pc_funsel = FS_INC;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed bench: three sequencer instances (low-first, high-first, short
// timeout) driving behavioural IR/PC registers and a byte memory.
module tb_ir_fetch_sequencer;
  import ir_fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic start, ack;
  int   sel;
  logic [7:0] mem [256];

  logic        ld;
  logic [15:0] ld_ir, ld_pc;

  logic        a_start, a_ack, a_req, a_ir_e, a_pc_e, a_busy, a_done, a_err;
  logic [15:0] a_addr, a_ir_i, ir_a, pc_a;
  logic [2:0]  a_ir_fs, a_pc_fs;
  logic [7:0]  a_data;
  logic        b_start, b_ack, b_req, b_ir_e, b_pc_e, b_busy, b_done, b_err;
  logic [15:0] b_addr, b_ir_i, ir_b, pc_b;
  logic [2:0]  b_ir_fs, b_pc_fs;
  logic [7:0]  b_data;
  logic        c_start, c_ack, c_req, c_ir_e, c_pc_e, c_busy, c_done, c_err;
  logic [15:0] c_addr, c_ir_i, ir_c, pc_c;
  logic [2:0]  c_ir_fs, c_pc_fs;
  logic [7:0]  c_data;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);
  assign c_start = start && (sel == 2);
  assign a_ack   = ack && (sel == 0);
  assign b_ack   = ack && (sel == 1);
  assign c_ack   = ack && (sel == 2);
  assign a_data  = mem[a_addr[7:0]];
  assign b_data  = mem[b_addr[7:0]];
  assign c_data  = mem[c_addr[7:0]];

  ir_fetch_sequencer #(.TIMEOUT(16), .LOW_FIRST(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_pc_q(pc_a),
    .o_mem_req(a_req), .o_mem_addr(a_addr), .i_mem_ack(a_ack), .i_mem_data(a_data),
    .o_ir_e(a_ir_e), .o_ir_funsel(a_ir_fs), .o_ir_i(a_ir_i), .o_pc_e(a_pc_e),
    .o_pc_funsel(a_pc_fs), .o_busy(a_busy), .o_done(a_done), .o_err(a_err));

  ir_fetch_sequencer #(.TIMEOUT(16), .LOW_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_pc_q(pc_b),
    .o_mem_req(b_req), .o_mem_addr(b_addr), .i_mem_ack(b_ack), .i_mem_data(b_data),
    .o_ir_e(b_ir_e), .o_ir_funsel(b_ir_fs), .o_ir_i(b_ir_i), .o_pc_e(b_pc_e),
    .o_pc_funsel(b_pc_fs), .o_busy(b_busy), .o_done(b_done), .o_err(b_err));

  ir_fetch_sequencer #(.TIMEOUT(4), .LOW_FIRST(1'b1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_pc_q(pc_c),
    .o_mem_req(c_req), .o_mem_addr(c_addr), .i_mem_ack(c_ack), .i_mem_data(c_data),
    .o_ir_e(c_ir_e), .o_ir_funsel(c_ir_fs), .o_ir_i(c_ir_i), .o_pc_e(c_pc_e),
    .o_pc_funsel(c_pc_fs), .o_busy(c_busy), .o_done(c_done), .o_err(c_err));

  logic        m_req, m_ir_e, m_pc_e, m_busy, m_done, m_err;
  logic [15:0] m_addr, m_ir_i;
  logic [2:0]  m_ir_fs, m_pc_fs;
  logic [7:0]  m_data;

  always_comb begin
    {m_req, m_ir_e, m_pc_e, m_busy, m_done, m_err} = {a_req, a_ir_e, a_pc_e, a_busy, a_done, a_err};
    m_addr = a_addr; m_ir_i = a_ir_i; m_ir_fs = a_ir_fs; m_pc_fs = a_pc_fs; m_data = a_data;
    if (sel == 1) begin
      {m_req, m_ir_e, m_pc_e, m_busy, m_done, m_err} = {b_req, b_ir_e, b_pc_e, b_busy, b_done, b_err};
      m_addr = b_addr; m_ir_i = b_ir_i; m_ir_fs = b_ir_fs; m_pc_fs = b_pc_fs; m_data = b_data;
    end else if (sel == 2) begin
      {m_req, m_ir_e, m_pc_e, m_busy, m_done, m_err} = {c_req, c_ir_e, c_pc_e, c_busy, c_done, c_err};
      m_addr = c_addr; m_ir_i = c_ir_i; m_ir_fs = c_ir_fs; m_pc_fs = c_pc_fs; m_data = c_data;
    end
  end

  // Behavioural FunSel register (IR) with I[7:0] as the byte source.
  function automatic logic [15:0] ir_next(input logic [15:0] q, input logic [2:0] fs,
                                          input logic [15:0] d);
    case (fs)
      FS_DEC:     return q - 16'd1;
      FS_INC:     return q + 16'd1;
      FS_LOAD:    return d;
      FS_CLR:     return 16'h0000;
      FS_WL_CLRH: return {8'h00, d[7:0]};
      FS_WL:      return {q[15:8], d[7:0]};
      FS_WH:      return {d[7:0], q[7:0]};
      default:    return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (ld) begin
      ir_a <= ld_ir; pc_a <= ld_pc;
      ir_b <= ld_ir; pc_b <= ld_pc;
      ir_c <= ld_ir; pc_c <= ld_pc;
    end else begin
      if (a_ir_e) ir_a <= ir_next(ir_a, a_ir_fs, a_ir_i);
      if (b_ir_e) ir_b <= ir_next(ir_b, b_ir_fs, b_ir_i);
      if (c_ir_e) ir_c <= ir_next(ir_c, c_ir_fs, c_ir_i);
      if (a_pc_e) pc_a <= (a_pc_fs == FS_INC) ? pc_a + 16'd1 : 16'hDEAD;
      if (b_pc_e) pc_b <= (b_pc_fs == FS_INC) ? pc_b + 16'd1 : 16'hDEAD;
      if (c_pc_e) pc_c <= (c_pc_fs == FS_INC) ? pc_c + 16'd1 : 16'hDEAD;
    end
  end

  int          obs_done_cyc, obs_err_cyc, obs_done_cnt, obs_err_cnt, obs_pc_e_cnt;
  int          obs_addr_bad, obs_iri_bad, obs_both, obs_extra;
  int          obs_pulses [2];
  int          obs_req [2];
  logic [2:0]  obs_fs [2];
  logic [15:0] obs_addr [2];

  task automatic load_regs(input logic [15:0] ir, input logic [15:0] pc);
    @(negedge clk);
    ld_ir = ir; ld_pc = pc; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Start at cycle 0; a byte is acked after `wait` cycles of MemReq (-1: never).
  task automatic run_fetch(input int wait0, input int wait1, input bit busy_start);
    int bi, rc, w;
    bi = 0; rc = 0;
    obs_done_cyc = -1; obs_err_cyc = -1; obs_done_cnt = 0; obs_err_cnt = 0;
    obs_pc_e_cnt = 0; obs_addr_bad = 0; obs_iri_bad = 0; obs_both = 0; obs_extra = 0;
    for (int k = 0; k < 2; k++) begin
      obs_pulses[k] = 0; obs_req[k] = 0; obs_fs[k] = 3'bxxx; obs_addr[k] = 16'hxxxx;
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (busy_start && cyc >= 1 && cyc <= 3);
      ack = 1'b0;
      if (m_req) begin
        if (bi > 1) obs_extra++;
        else begin
          w = (bi == 0) ? wait0 : wait1;
          if (rc == 0) obs_addr[bi] = m_addr;
          else if (m_addr !== obs_addr[bi]) obs_addr_bad++;
          obs_req[bi]++;
          if (w >= 0 && rc == w) ack = 1'b1;
          rc++;
        end
      end
      #1;
      if (m_ir_e) begin
        if (bi > 1 || !ack) obs_extra++;
        else begin
          obs_pulses[bi]++;
          obs_fs[bi] = m_ir_fs;
          if (m_ir_i !== {8'h00, m_data}) obs_iri_bad++;
        end
      end
      if (m_pc_e) obs_pc_e_cnt++;
      if (m_done) begin obs_done_cnt++; obs_done_cyc = cyc; end
      if (m_err) begin obs_err_cnt++; obs_err_cyc = cyc; end
      if (m_done && m_err) obs_both++;
      if (ack) begin bi++; rc = 0; end
    end
    start = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; ack = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_cmp++;
      if ({m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e} !== 6'b0) begin
        n_bad++; $display("FAIL reset_outputs dut%0d: got %b expected 000000", s,
                          {m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e});
      end
      n_cmp++;
      if (m_pc_fs !== FS_INC) begin
        n_bad++; $display("FAIL pc_funsel dut%0d: got %b expected 001", s, m_pc_fs);
      end
    end
    repeat (2) @(negedge clk);
    start = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s; ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e} !== 6'b0) begin
        n_bad++; $display("FAIL idle_ack_ignored dut%0d: got %b expected 000000", s,
                          {m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e});
      end
      ack = 1'b0;
    end
  endtask

  task automatic test_zero_wait;
    sel = 0;
    load_regs(16'hFFFF, 16'h0010);
    run_fetch(0, 0, 1'b0);
    n_cmp++; if (ir_a !== 16'h1234) begin n_bad++; $display("FAIL zw_ir: got %h expected 1234", ir_a); end
    n_cmp++; if (pc_a !== 16'h0012) begin n_bad++; $display("FAIL zw_pc: got %h expected 0012", pc_a); end
    n_cmp++; if (obs_done_cyc != 3 || obs_done_cnt != 1) begin
      n_bad++; $display("FAIL zw_done: got cycle %0d count %0d expected cycle 3 count 1", obs_done_cyc, obs_done_cnt); end
    n_cmp++; if (obs_err_cnt != 0) begin n_bad++; $display("FAIL zw_err: got %0d expected 0", obs_err_cnt); end
    n_cmp++; if (obs_fs[0] !== FS_WL_CLRH || obs_fs[1] !== FS_WH) begin
      n_bad++; $display("FAIL zw_funsel: got %b,%b expected 100,110", obs_fs[0], obs_fs[1]); end
    n_cmp++; if (obs_addr[0] !== 16'h0010 || obs_addr[1] !== 16'h0011) begin
      n_bad++; $display("FAIL zw_addr: got %h,%h expected 0010,0011", obs_addr[0], obs_addr[1]); end
    n_cmp++; if (obs_pc_e_cnt != 2 || obs_iri_bad != 0 || obs_extra != 0) begin
      n_bad++; $display("FAIL zw_strobes: got pc_e %0d iri_bad %0d extra %0d expected 2 0 0",
                        obs_pc_e_cnt, obs_iri_bad, obs_extra); end
  endtask

  task automatic test_high_first;
    sel = 1;
    load_regs(16'hFFFF, 16'h0010);
    run_fetch(0, 0, 1'b0);
    n_cmp++; if (ir_b !== 16'h3412) begin n_bad++; $display("FAIL hf_ir: got %h expected 3412", ir_b); end
    n_cmp++; if (obs_fs[0] !== FS_WH || obs_fs[1] !== FS_WL) begin
      n_bad++; $display("FAIL hf_funsel: got %b,%b expected 110,101", obs_fs[0], obs_fs[1]); end
    n_cmp++; if (pc_b !== 16'h0012 || obs_done_cyc != 3) begin
      n_bad++; $display("FAIL hf_pc_done: got pc %h done %0d expected 0012 3", pc_b, obs_done_cyc); end
  endtask

  task automatic test_wait_states;
    sel = 0;
    load_regs(16'h0000, 16'h0010);
    run_fetch(3, 0, 1'b0);
    n_cmp++; if (obs_req[0] != 4 || obs_addr[0] !== 16'h0010 || obs_addr_bad != 0) begin
      n_bad++; $display("FAIL ws_req: got %0d cycles addr %h unstable %0d expected 4 0010 0",
                        obs_req[0], obs_addr[0], obs_addr_bad); end
    n_cmp++; if (obs_pulses[0] != 1 || obs_pulses[1] != 1 || obs_extra != 0) begin
      n_bad++; $display("FAIL ws_ir_e: got %0d,%0d extra %0d expected 1,1 0",
                        obs_pulses[0], obs_pulses[1], obs_extra); end
    n_cmp++; if (obs_done_cyc != 6 || obs_err_cnt != 0) begin
      n_bad++; $display("FAIL ws_done: got cycle %0d err %0d expected 6 0", obs_done_cyc, obs_err_cnt); end
    n_cmp++; if (ir_a !== 16'h1234 || pc_a !== 16'h0012) begin
      n_bad++; $display("FAIL ws_regs: got ir %h pc %h expected 1234 0012", ir_a, pc_a); end
  endtask

  task automatic test_timeout;
    sel = 2;
    load_regs(16'hABCD, 16'h0010);
    run_fetch(0, -1, 1'b0);
    n_cmp++; if (obs_err_cyc != 6 || obs_err_cnt != 1 || obs_done_cnt != 0 || obs_both != 0) begin
      n_bad++; $display("FAIL to1_err: got cycle %0d err %0d done %0d expected 6 1 0",
                        obs_err_cyc, obs_err_cnt, obs_done_cnt); end
    n_cmp++; if (ir_c !== 16'h0034 || pc_c !== 16'h0011) begin
      n_bad++; $display("FAIL to1_regs: got ir %h pc %h expected 0034 0011", ir_c, pc_c); end
    n_cmp++; if (obs_req[1] != 4 || obs_pulses[1] != 0 || obs_pc_e_cnt != 1) begin
      n_bad++; $display("FAIL to1_byte1: got req %0d ir_e %0d pc_e %0d expected 4 0 1",
                        obs_req[1], obs_pulses[1], obs_pc_e_cnt); end
    n_cmp++; if (m_busy !== 1'b0 || m_req !== 1'b0) begin
      n_bad++; $display("FAIL to1_idle: got busy %b req %b expected 0 0", m_busy, m_req); end
    load_regs(16'hABCD, 16'h0020);
    run_fetch(-1, 0, 1'b0);
    n_cmp++; if (obs_err_cyc != 5 || obs_req[0] != 4 || obs_pc_e_cnt != 0 || obs_pulses[0] != 0) begin
      n_bad++; $display("FAIL to0_err: got cycle %0d req %0d pc_e %0d ir_e %0d expected 5 4 0 0",
                        obs_err_cyc, obs_req[0], obs_pc_e_cnt, obs_pulses[0]); end
    n_cmp++; if (ir_c !== 16'hABCD || pc_c !== 16'h0020) begin
      n_bad++; $display("FAIL to0_regs: got ir %h pc %h expected abcd 0020", ir_c, pc_c); end
  endtask

  task automatic test_ack_on_limit;
    sel = 2;
    load_regs(16'hABCD, 16'h0010);
    run_fetch(3, 3, 1'b0);
    n_cmp++; if (obs_err_cnt != 0 || obs_done_cyc != 9 || obs_done_cnt != 1) begin
      n_bad++; $display("FAIL lim_done: got err %0d done cycle %0d count %0d expected 0 9 1",
                        obs_err_cnt, obs_done_cyc, obs_done_cnt); end
    n_cmp++; if (ir_c !== 16'h1234 || pc_c !== 16'h0012) begin
      n_bad++; $display("FAIL lim_regs: got ir %h pc %h expected 1234 0012", ir_c, pc_c); end
  endtask

  task automatic test_busy_start;
    sel = 0;
    load_regs(16'h0000, 16'h0010);
    run_fetch(0, 0, 1'b1);
    n_cmp++; if (obs_done_cnt != 1 || obs_done_cyc != 3 || obs_extra != 0 || obs_req[0] + obs_req[1] != 2) begin
      n_bad++; $display("FAIL busy_start: got done %0d at %0d extra %0d req %0d expected 1 3 0 2",
                        obs_done_cnt, obs_done_cyc, obs_extra, obs_req[0] + obs_req[1]); end
    n_cmp++; if (ir_a !== 16'h1234 || pc_a !== 16'h0012) begin
      n_bad++; $display("FAIL busy_regs: got ir %h pc %h expected 1234 0012", ir_a, pc_a); end
  endtask

  task automatic test_reset_mid_fetch;
    int act;
    sel = 2;
    load_regs(16'h0000, 16'h0010);
    @(negedge clk); start = 1'b1; ack = 1'b0;
    @(negedge clk); start = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0; start = 1'b1;
    #1;
    n_cmp++; if (m_busy !== 1'b1 || m_req !== 1'b1 || m_addr !== 16'h0011) begin
      n_bad++; $display("FAIL rst_pre: got busy %b req %b addr %h expected 1 1 0011", m_busy, m_req, m_addr); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e} !== 6'b0) begin
      n_bad++; $display("FAIL rst_async: got %b expected 000000", {m_req, m_busy, m_done, m_err, m_ir_e, m_pc_e}); end
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (m_req || m_busy || m_done || m_err) act++;
    end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL rst_quiet: got %0d active cycles expected 0", act); end
    n_cmp++; if (ir_c !== 16'h0034 || pc_c !== 16'h0011) begin
      n_bad++; $display("FAIL rst_regs: got ir %h pc %h expected 0034 0011", ir_c, pc_c); end
  endtask

  initial begin
    ld = 1'b0; ld_ir = 16'h0000; ld_pc = 16'h0000;
    start = 1'b0; ack = 1'b0; sel = 0; rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    test_reset();
    test_zero_wait();
    test_high_first();
    test_wait_states();
    test_timeout();
    test_ack_on_limit();
    test_busy_start();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
Upstream control stage that fetches one 16-bit instruction from the byte-wide instruction memory in two byte transactions. It drives the E/FunSel/I inputs of the Instruction Register (a 16-bit FunSel-controlled register) and the E/FunSel inputs of the PC register. The block uses a req/ack memory handshake with a per-byte timeout. It sits between the top-level control unit (Start/Done) and the IR/PC register instances.

Parameters:
TIMEOUT, 16, max cycles MemReq may stay high without MemAck before abort (1..255)
LOW_FIRST, 1, 1 = first byte fetched goes to IR[7:0]; 0 = first byte goes to IR[15:8]

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  request one instruction fetch; sampled only in IDLE
PC_Q  in  16  current PC register value
MemReq  out  1  memory read request, held until MemAck
MemAddr  out  16  read address; combinationally equal to PC_Q
MemAck  in  1  memory read complete; MemData valid in the same cycle
MemData  in  8  read byte
IR_E  out  1  IR enable
IR_FunSel  out  3  IR function select
IR_I  out  16  IR data input; always {8'h00, MemData}
PC_E  out  1  PC enable
PC_FunSel  out  3  PC function select; constant 3'b001 (increment)
Busy  out  1  fetch in progress
Done  out  1  one-cycle pulse after a successful fetch
Err  out  1  one-cycle pulse after a timeout abort

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, timeout counter=0. Under reset, MemReq, IR_E, PC_E, Busy, Done and Err are all 0.
- States: IDLE, BYTE0, BYTE1, DONE, ERR. State is registered. IR_E and PC_E are Mealy outputs; all other outputs are decoded from state.
- IDLE: Busy=0, MemReq=0. If Start=1, go to BYTE0 next cycle. Any MemAck in IDLE is ignored.
- BYTE0: Busy=1, MemReq=1.
  - In a cycle with MemAck=1: IR_E=1, IR_FunSel=3'b100 if LOW_FIRST (clear high byte, write low byte), else 3'b110 (write high byte only); PC_E=1; go to BYTE1.
  - IR and PC therefore update on the same edge. MemAddr in BYTE1 equals the old PC+1.
- BYTE1: Busy=1, MemReq=1.
  - In a cycle with MemAck=1: IR_E=1, IR_FunSel=3'b110 if LOW_FIRST, else 3'b101 (write low byte only); PC_E=1; go to DONE.
- DONE: Done=1, Busy=0, MemReq=0; go to IDLE. Start in DONE is ignored; the next fetch needs Start in IDLE.
- ERR: Err=1, Busy=0; go to IDLE. The IR keeps any byte already written. The PC keeps any increment already applied. Fetch latency with zero-wait memory: Start at cycle 0, BYTE0 ack at cycle 1, BYTE1 ack at cycle 2, Done at cycle 3.
- Timeout counter:
  - Clears on entry to BYTE0 and BYTE1, and on each ack.
  - Increments each cycle in BYTE0/BYTE1 while MemAck=0.
  - When the count reaches TIMEOUT-1 with MemAck=0, go to ERR. No IR or PC write happens in that cycle.
  - If MemAck=1 in the same cycle the counter hits its limit, the ack wins: normal write and transition.
- Outside an ack cycle in BYTE0/BYTE1, IR_E=0 and PC_E=0. Outside BYTE0/BYTE1, IR_E and PC_E are always 0.
- Start while Busy=1 is ignored; it is not queued.
- Reset asserted mid-fetch returns the block to IDLE immediately and drops MemReq asynchronously. No Done or Err pulse is produced. The IR and PC registers have no reset and keep their contents.
- Only one of Done and Err can be 1 in any cycle.

Decomposition:
- Shared package/defines file:
  - FunSel constants: FS_DEC=3'b000, FS_INC=3'b001, FS_LOAD=3'b010, FS_CLR=3'b011, FS_WL_CLRH=3'b100, FS_WL=3'b101, FS_WH=3'b110, FS_SEXT=3'b111.
  - FSM state encodings (3-bit).
- One natural sub-module: fetch_timeout_counter (clear/enable inputs, terminal-count output, parameterised by TIMEOUT).
- FSM and output decode stay in ir_fetch_sequencer.

Test Plan:
- Zero-wait fetch, LOW_FIRST=1, PC=16'h0010, mem[0x10]=8'h34, mem[0x11]=8'h12 -> IR=16'h1234, PC=16'h0012, Done pulses at cycle 3, Err stays 0.
- LOW_FIRST=0, same memory -> IR=16'h3412 after fetch; IR_FunSel sequence is 110 then 101.
- 3 wait cycles on byte 0 -> MemReq held for 4 cycles at MemAddr=16'h0010, MemAddr stays stable, exactly one IR_E pulse per byte, Done at cycle 6.
- No ack on byte 1 with TIMEOUT=4 -> Err pulses once, IR[7:0]=byte0, PC incremented once, state returns to IDLE, Done never asserts.
- MemAck on the exact timeout cycle -> byte is written, no Err, Done follows.
- Reset=0 during BYTE1, plus Start pulsed while Busy -> outputs go to 0 immediately, no Done/Err; the extra Start does not launch a second fetch.
